mysystem_pio_master: RTL and testbench

- Avalon-MM master that drives the single-port PIO slaves in mysystem, such as the SDRAM clock control PIO.
- Accepts commands over a valid/ready interface: write, read, or poll-until-match.
- Issues the corresponding chipselect/write_n transactions and returns one response per command.
- Lets hardware sequencers toggle PIO outputs and wait on PIO inputs without the Nios core.

---
 rtl/mysystem_pio_master.sv | 177 +++++++++++++++++
 tb/tb_mysystem_pio_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mysystem_pio_master.sv
// rtl/mysystem_pio_master.sv - Avalon-MM master issuing write/read/poll cycles to single-port PIO slaves
module mysystem_pio_master #(
    parameter int READ_LATENCY = 1,
    parameter int POLL_GAP     = 4,
    parameter int POLL_LIMIT   = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_address,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic [1:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [31:0] av_writedata,
    input  logic [31:0] av_readdata
);

    localparam int              AW        = $clog2(POLL_LIMIT + 1);
    localparam logic [AW-1:0]   ATT_LAST  = AW'(POLL_LIMIT);
    localparam logic [1:0]      WAIT_LAST = 2'(READ_LATENCY - 1);
    localparam logic [7:0]      GAP_LAST  = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RWAIT,
        S_GAP,
        S_RSP
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [1:0]    op_q;
    logic [31:0]   data_q;
    logic [31:0]   mask_q;
    logic [AW-1:0] attempts;
    logic [1:0]    wait_cnt;
    logic [7:0]    gap_cnt;

    logic is_poll;
    logic match;
    logic sample_now;

    assign is_poll    = (op_q == OP_POLL);
    assign match      = ((av_readdata & mask_q) == (data_q & mask_q));
    assign sample_now = (state == S_RWAIT) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        av_chipselect = 1'b0;
        av_write_n    = 1'b1;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: next_state = S_WR;
                        OP_READ:  next_state = S_RD;
                        OP_POLL:  next_state = S_RD;
                        default:  next_state = S_RSP;
                    endcase
                end
            end
            S_WR: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                next_state    = S_RSP;
            end
            S_RD: begin
                av_chipselect = 1'b1;
                next_state    = S_RWAIT;
            end
            S_RWAIT: begin
                if (sample_now) begin
                    if (!is_poll || match || attempts == ATT_LAST) begin
                        next_state = S_RSP;
                    end else if (POLL_GAP == 0) begin
                        next_state = S_RD;
                    end else begin
                        next_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    next_state = S_RD;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Command fields are captured only at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q         <= 2'b00;
            data_q       <= 32'd0;
            mask_q       <= 32'd0;
            attempts     <= '0;
            wait_cnt     <= 2'd0;
            gap_cnt      <= 8'd0;
            rsp_data     <= 32'd0;
            rsp_timeout  <= 1'b0;
            av_address   <= 2'd0;
            av_writedata <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        data_q      <= cmd_data;
                        mask_q      <= cmd_mask;
                        av_address  <= cmd_address;
                        attempts    <= '0;
                        rsp_data    <= 32'd0;
                        rsp_timeout <= 1'b0;
                        if (cmd_op == OP_WRITE) begin
                            av_writedata <= cmd_data;
                        end
                    end
                end
                S_RD: begin
                    wait_cnt <= 2'd0;
                    if (is_poll) begin
                        attempts <= attempts + AW'(1);
                    end
                end
                S_RWAIT: begin
                    if (sample_now) begin
                        rsp_data <= av_readdata;
                        gap_cnt  <= 8'd0;
                        if (is_poll && !match && attempts == ATT_LAST) begin
                            rsp_timeout <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mysystem_pio_master.sv
// tb/tb_mysystem_pio_master.sv - directed scoreboard bench for mysystem_pio_master
module tb_mysystem_pio_master;

    localparam int RL = 1;
    localparam int PG = 4;
    localparam int PL = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [1:0]  cmd_address = 2'b00;
    logic [31:0] cmd_data = 32'd0;
    logic [31:0] cmd_mask = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic [1:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata = 32'd0;

    mysystem_pio_master #(
        .READ_LATENCY(RL),
        .POLL_GAP(PG),
        .POLL_LIMIT(PL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_address(cmd_address),
        .cmd_data(cmd_data),
        .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout),
        .av_address(av_address),
        .av_chipselect(av_chipselect),
        .av_write_n(av_write_n),
        .av_writedata(av_writedata),
        .av_readdata(av_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: register 0 is the input port, other addresses read zero.
    logic in_port = 1'b0;
    always @(posedge clk) av_readdata <= (av_address == 2'd0) ? {31'd0, in_port} : 32'd0;

    logic        mon_clr = 1'b0;
    int          cs_cnt = 0, wr_cnt = 0, rd_cnt = 0, idle_run = 0, gap_min = 9999, gap_max = 0;
    logic        seen_cs = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = 32'd0;

    always @(negedge clk) begin
        if (mon_clr) begin
            cs_cnt <= 0; wr_cnt <= 0; rd_cnt <= 0; idle_run <= 0;
            gap_min <= 9999; gap_max <= 0; seen_cs <= 1'b0;
        end else if (reset_n) begin
            if (av_chipselect) begin
                cs_cnt <= cs_cnt + 1;
                if (!av_write_n) begin
                    wr_cnt  <= wr_cnt + 1;
                    wr_addr <= av_address;
                    wr_data <= av_writedata;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                end
                if (seen_cs) begin
                    if (idle_run < gap_min) gap_min <= idle_run;
                    if (idle_run > gap_max) gap_max <= idle_run;
                end
                seen_cs  <= 1'b1;
                idle_run <= 0;
            end else begin
                idle_run <= idle_run + 1;
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        timeout;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int accept_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] addr, input logic [31:0] data,
                        input logic [31:0] mask, input logic push, input logic [31:0] exp_data,
                        input logic exp_to);
        int n;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_address = addr; cmd_data = data; cmd_mask = mask;
        if (push) begin
            e.data = exp_data; e.timeout = exp_to;
            sb.push_back(e);
        end
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_address = 2'd3;
        cmd_data = 32'hDEAD_BEEF; cmd_mask = 32'hFFFF_FFFF;
    endtask

    task automatic get_rsp(input string tag, input int exp_lat);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        if (exp_lat >= 0) check({tag, "_latency"}, cyc - accept_cyc + 1, exp_lat);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, rsp_data, e.data);
            check({tag, "_timeout"}, 32'(rsp_timeout), 32'(e.timeout));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        check({tag, "_chipselect"}, 32'(av_chipselect), 32'd0);
        check({tag, "_write_n"}, 32'(av_write_n), 32'd1);
        check({tag, "_address"}, 32'(av_address), 32'd0);
        check({tag, "_writedata"}, av_writedata, 32'd0);
    endtask

    initial begin
        int n;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Write: one strobe cycle, response two cycles after accept.
        clear_mon();
        send(2'b00, 2'd0, 32'h1, 32'h0, 1'b1, 32'h0, 1'b0);
        get_rsp("write", 2);
        check("write_cs_cycles", cs_cnt, 1);
        check("write_strobes", wr_cnt, 1);
        check("write_addr", 32'(wr_addr), 32'd0);
        check("write_data", wr_data, 32'h1);

        // Reads at address 0 (in_port=1) and address 1.
        in_port = 1'b1;
        clear_mon();
        send(2'b01, 2'd0, 32'h0, 32'h0, 1'b1, 32'h1, 1'b0);
        get_rsp("read0", 2 + RL);
        check("read0_cs_cycles", cs_cnt, 1);
        check("read0_no_write", wr_cnt, 0);
        send(2'b01, 2'd1, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
        get_rsp("read1", 2 + RL);

        // Poll matching on the 4th read.
        in_port = 1'b0;
        clear_mon();
        send(2'b10, 2'd0, 32'h1, 32'h1, 1'b1, 32'h1, 1'b0);
        n = 0;
        while (rd_cnt < 3 && n < 200) begin @(negedge clk); n++; end
        check("poll_third_read_seen", rd_cnt, 3);
        repeat (2) @(negedge clk);
        in_port = 1'b1;
        get_rsp("poll_match", 4 * (1 + RL) + 3 * PG + 1);
        check("poll_match_reads", rd_cnt, 4);
        check("poll_gap_min", gap_min, RL + PG);
        check("poll_gap_max", gap_max, RL + PG);

        // Poll timeout after exactly PL reads.
        in_port = 1'b0;
        clear_mon();
        send(2'b10, 2'd0, 32'h1, 32'h1, 1'b1, 32'h0, 1'b1);
        get_rsp("poll_timeout", PL * (1 + RL) + (PL - 1) * PG + 1);
        check("poll_timeout_reads", rd_cnt, PL);

        // Zero mask matches on the first read; reserved op does no bus cycle.
        clear_mon();
        send(2'b10, 2'd1, 32'h5, 32'h0, 1'b1, 32'h0, 1'b0);
        get_rsp("poll_mask0", 2 + RL);
        check("poll_mask0_reads", rd_cnt, 1);
        clear_mon();
        send(2'b11, 2'd2, 32'h1234, 32'h0, 1'b1, 32'h0, 1'b0);
        get_rsp("reserved", 1);
        check("reserved_cs_cycles", cs_cnt, 0);

        // Backpressure: response held for 10 cycles, new command ignored.
        in_port = 1'b1;
        rsp_ready = 1'b0;
        clear_mon();
        send(2'b01, 2'd0, 32'h0, 32'h0, 1'b1, 32'h1, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_address = 2'd2; cmd_data = 32'h55;
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", rsp_data, 32'h1);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_chipselect", 32'(av_chipselect), 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        get_rsp("backpressure", -1);
        repeat (3) @(negedge clk);
        check("bp_ignored_write", wr_cnt, 0);

        // Reset asserted while the poll sits in its gap.
        in_port = 1'b0;
        clear_mon();
        send(2'b10, 2'd1, 32'h1, 32'h1, 1'b0, 32'h0, 1'b0);
        n = 0;
        while (rd_cnt < 1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        check("rst_in_gap_cs", 32'(av_chipselect), 32'd0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        check("midreset_no_rsp", 32'(rsp_valid), 32'd0);
        check("midreset_no_reads", rd_cnt, 1);
        reset_n = 1'b1;
        in_port = 1'b1;
        send(2'b01, 2'd0, 32'h0, 32'h0, 1'b1, 32'h1, 1'b0);
        get_rsp("after_reset_read", 2 + RL);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
